// File: rtl/switch_debouncer_if.sv
// Switch-side bundle for switch_debouncer: raw levels in; debounced levels and edge pulses out.
// The debouncer takes the slave view; whoever drives the raw switches takes the master view.
interface switch_debouncer_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] O;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;

  modport master (output I, input O, input RISE, input FALL);
  modport slave  (input I, output O, output RISE, output FALL);
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit switch debouncer: two-flop synchroniser, then a stability counter that accepts a new
// level only after it has been seen for STABLE_CYCLES consecutive clocks, with one-cycle edge pulses.
module switch_debouncer #(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 50000,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  switch_debouncer_if.slave sw
);

  localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1 || (64'd1 << COUNT_WIDTH) <= 64'(STABLE_CYCLES - 1)) begin : g_bad_params
    $error("switch_debouncer: STABLE_CYCLES must be >= 1 and fit in COUNT_WIDTH bits");
  end

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw.I;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   o_q, o_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Any cycle that agrees with the current output restarts qualification from zero.
    always_comb begin
      cnt_d  = cnt_q;
      o_d    = o_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync2_q[gi] == o_q) begin
        cnt_d = '0;
      end else if (cnt_q != LAST_CNT) begin
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      end else begin
        o_d    = sync2_q[gi];
        cnt_d  = '0;
        rise_d = sync2_q[gi];
        fall_d = ~sync2_q[gi];
      end
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        cnt_q  <= '0;
        o_q    <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        o_q    <= o_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign sw.O[gi]    = o_q;
    assign sw.RISE[gi] = rise_q;
    assign sw.FALL[gi] = fall_q;
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: stimulus queues expected pulse events, per-DUT monitors
// compare them and the held output level every cycle. DUT a uses STABLE_CYCLES=4, DUT b uses 1.
module tb_switch_debouncer;

  typedef struct {
    int       cyc;
    logic [2:0] o;
    logic [2:0] rise;
    logic [2:0] fall;
  } ev_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ev_t  q_a[$];
  ev_t  q_b[$];
  logic [2:0] o_exp_a = '0;
  logic [2:0] o_exp_b = '0;

  switch_debouncer_if #(.WIDTH(3)) if_a ();
  switch_debouncer_if #(.WIDTH(3)) if_b ();

  switch_debouncer #(.WIDTH(3), .STABLE_CYCLES(4), .COUNT_WIDTH(3)) dut_a (
    .CLK  (clk),
    .RESET(rst_a),
    .sw   (if_a.slave)
  );

  switch_debouncer #(.WIDTH(3), .STABLE_CYCLES(1), .COUNT_WIDTH(1)) dut_b (
    .CLK  (clk),
    .RESET(rst_b),
    .sw   (if_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_a(input int c, input logic [2:0] o, input logic [2:0] r, input logic [2:0] f);
    ev_t e;
    e.cyc = c; e.o = o; e.rise = r; e.fall = f;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int c, input logic [2:0] o, input logic [2:0] r, input logic [2:0] f);
    ev_t e;
    e.cyc = c; e.o = o; e.rise = r; e.fall = f;
    q_b.push_back(e);
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cyc %0d)", name, act, exp, cyc);
    end else begin
      $display("check %s: %b ok (cyc %0d)", name, act, cyc);
    end
  endtask

  // Monitor for DUT a: every pulse must match the next queued event; otherwise O must hold.
  always @(negedge clk) begin
    if (rst_a) begin
      o_exp_a = '0;
    end else if (if_a.RISE != 3'b000 || if_a.FALL != 3'b000) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_pulse: cyc %0d O=%b RISE=%b FALL=%b, expected no pulse",
                 cyc, if_a.O, if_a.RISE, if_a.FALL);
      end else begin
        ev_t e;
        e = q_a.pop_front();
        if (cyc != e.cyc || if_a.O !== e.o || if_a.RISE !== e.rise || if_a.FALL !== e.fall) begin
          errors++;
          $display("FAIL a_event: got cyc %0d O=%b RISE=%b FALL=%b, expected cyc %0d O=%b RISE=%b FALL=%b",
                   cyc, if_a.O, if_a.RISE, if_a.FALL, e.cyc, e.o, e.rise, e.fall);
        end else begin
          $display("event a: cyc %0d O=%b RISE=%b FALL=%b ok", cyc, if_a.O, if_a.RISE, if_a.FALL);
        end
        o_exp_a = e.o;
      end
    end else begin
      checks++;
      if (if_a.O !== o_exp_a) begin
        errors++;
        $display("FAIL a_level_hold: cyc %0d O=%b, expected %b", cyc, if_a.O, o_exp_a);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      o_exp_b = '0;
    end else if (if_b.RISE != 3'b000 || if_b.FALL != 3'b000) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_pulse: cyc %0d O=%b RISE=%b FALL=%b, expected no pulse",
                 cyc, if_b.O, if_b.RISE, if_b.FALL);
      end else begin
        ev_t e;
        e = q_b.pop_front();
        if (cyc != e.cyc || if_b.O !== e.o || if_b.RISE !== e.rise || if_b.FALL !== e.fall) begin
          errors++;
          $display("FAIL b_event: got cyc %0d O=%b RISE=%b FALL=%b, expected cyc %0d O=%b RISE=%b FALL=%b",
                   cyc, if_b.O, if_b.RISE, if_b.FALL, e.cyc, e.o, e.rise, e.fall);
        end else begin
          $display("event b: cyc %0d O=%b RISE=%b FALL=%b ok", cyc, if_b.O, if_b.RISE, if_b.FALL);
        end
        o_exp_b = e.o;
      end
    end else begin
      checks++;
      if (if_b.O !== o_exp_b) begin
        errors++;
        $display("FAIL b_level_hold: cyc %0d O=%b, expected %b", cyc, if_b.O, o_exp_b);
      end
    end
  end

  initial begin
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    if_a.I = 3'b111;
    if_b.I = 3'b000;
    repeat (3) @(negedge clk);
    check3("reset_O", if_a.O, 3'b000);
    check3("reset_RISE", if_a.RISE, 3'b000);
    check3("reset_FALL", if_a.FALL, 3'b000);
    check3("reset_b_O", if_b.O, 3'b000);

    // Release with switches held high: accepted on edge 5 counted from the first edge after release.
    rst_a = 1'b0;
    rst_b = 1'b0;
    push_a(cyc + 6, 3'b111, 3'b111, 3'b000);
    repeat (12) @(negedge clk);

    // Partial release: bits 0 and 2 fall together.
    if_a.I = 3'b010;
    push_a(cyc + 6, 3'b010, 3'b000, 3'b101);
    repeat (10) @(negedge clk);
    if_a.I = 3'b000;
    push_a(cyc + 6, 3'b000, 3'b000, 3'b010);
    repeat (10) @(negedge clk);

    // Single-bit press.
    if_a.I = 3'b001;
    push_a(cyc + 6, 3'b001, 3'b001, 3'b000);
    repeat (10) @(negedge clk);

    // Glitch: three high cycles are not enough; qualification restarts at the final rise.
    if_a.I = 3'b011;
    repeat (3) @(negedge clk);
    if_a.I = 3'b001;
    @(negedge clk);
    if_a.I = 3'b011;
    push_a(cyc + 6, 3'b011, 3'b010, 3'b000);
    repeat (12) @(negedge clk);
    check3("glitch_O", if_a.O, 3'b011);

    // Reset mid-count (bit 2 counter at 2) between clock edges.
    if_a.I = 3'b100;
    repeat (4) @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    check3("async_rst_O", if_a.O, 3'b000);
    check3("async_rst_RISE", if_a.RISE, 3'b000);
    check3("async_rst_FALL", if_a.FALL, 3'b000);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    push_a(cyc + 6, 3'b100, 3'b100, 3'b000);
    repeat (12) @(negedge clk);
    check3("post_rst_O", if_a.O, 3'b100);

    // STABLE_CYCLES=1: each change of I[2] shows up two edges after edge 0.
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        if_b.I = 3'b100;
        push_b(cyc + 3, 3'b100, 3'b100, 3'b000);
      end else begin
        if_b.I = 3'b000;
        push_b(cyc + 3, 3'b000, 3'b000, 3'b100);
      end
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check3("b_final_O", if_b.O, 3'b000);

    checks++;
    if (q_a.size() != 0) begin
      errors++;
      $display("FAIL a_missing_events: %0d events never seen, expected 0", q_a.size());
    end
    checks++;
    if (q_b.size() != 0) begin
      errors++;
      $display("FAIL b_missing_events: %0d events never seen, expected 0", q_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
